// File: rtl/noc_flit_packetizer_pkg.sv
// Shared types for the injection-side packetizer: flit labels, FSM states,
// flit layout at the default mesh geometry, and head-flit encode/decode helpers.
package noc_flit_packetizer_pkg;

    localparam int DEF_MESH_SIZE_X   = 9;
    localparam int DEF_MESH_SIZE_Y   = 5;
    localparam int DEF_VC_NUM        = 2;
    localparam int DEF_MAX_PKT_WORDS = 8;

    localparam int DEST_X_W    = (DEF_MESH_SIZE_X > 1) ? $clog2(DEF_MESH_SIZE_X) : 1;
    localparam int DEST_Y_W    = (DEF_MESH_SIZE_Y > 1) ? $clog2(DEF_MESH_SIZE_Y) : 1;
    localparam int PAYLOAD_W   = 64;
    localparam int VC_W        = (DEF_VC_NUM > 1) ? $clog2(DEF_VC_NUM) : 1;
    localparam int LEN_W       = $clog2(DEF_MAX_PKT_WORDS + 1);
    localparam int ADDR_W      = DEST_X_W + DEST_Y_W;
    localparam int FLIT_DATA_W = 2 * ADDR_W + PAYLOAD_W;
    localparam int FLIT_W      = 2 + VC_W + FLIT_DATA_W;

    typedef enum logic [1:0] {
        LBL_HEAD     = 2'd0,
        LBL_BODY     = 2'd1,
        LBL_TAIL     = 2'd2,
        LBL_HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } packetizer_state_t;

    typedef struct packed {
        flit_label_t             label;
        logic [VC_W-1:0]         vc_id;
        logic [FLIT_DATA_W-1:0]  data;
    } flit_t;

    function automatic flit_t encode_head_flit(
        input logic [DEST_X_W-1:0]  x,
        input logic [DEST_Y_W-1:0]  y,
        input logic [ADDR_W-1:0]    src,
        input logic [PAYLOAD_W-1:0] word,
        input flit_label_t          label,
        input logic [VC_W-1:0]      vc
    );
        flit_t f;
        f.label = label;
        f.vc_id = vc;
        f.data  = {x, y, src, word};
        return f;
    endfunction

    function automatic logic [ADDR_W-1:0] decode_packet_destination(input flit_t f);
        return f.data[FLIT_DATA_W-1 -: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] decode_packet_source(input flit_t f);
        return f.data[FLIT_DATA_W-ADDR_W-1 -: ADDR_W];
    endfunction

endpackage

// File: rtl/noc_flit_packetizer_credit.sv
// Per-VC credit counter: starts full, saturates at BUFFER_DEPTH and flags any
// credit return that would push it past the router buffer depth.
module noc_credit_counter #(
    parameter  int BUFFER_DEPTH = 4,
    localparam int CNT_BITS     = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic                nonzero_o,
    output logic                ovf_o
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    // Next count; a matched inc/dec pair cancels out
    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == CNT_BITS'(BUFFER_DEPTH)) begin
                ovf_o = 1'b1;
            end else begin
                count_d = count_q + CNT_BITS'(1);
            end
        end else if (dec_i && !inc_i && (count_q != {CNT_BITS{1'b0}})) begin
            count_d = count_q - CNT_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_BITS'(BUFFER_DEPTH);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != {CNT_BITS{1'b0}});

endmodule

// File: rtl/noc_flit_packetizer.sv
// Network-interface packetizer: turns a header plus payload words into a
// HEAD/BODY/TAIL (or HEADTAIL) flit train on one credit-gated, round-robin VC.
module noc_flit_packetizer
    import noc_flit_packetizer_pkg::*;
#(
    parameter  int VC_NUM             = 2,
    parameter  int BUFFER_DEPTH       = 4,
    parameter  int MAX_PKT_WORDS      = 8,
    parameter  int PAYLOAD_DATA_WIDTH = 64,
    parameter  int MESH_SIZE_X        = 9,
    parameter  int MESH_SIZE_Y        = 5,
    parameter  int NODE_X             = 0,
    parameter  int NODE_Y             = 0,
    localparam int VC_BITS   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int LEN_BITS  = $clog2(MAX_PKT_WORDS + 1),
    localparam int DX_BITS   = (MESH_SIZE_X > 1) ? $clog2(MESH_SIZE_X) : 1,
    localparam int DY_BITS   = (MESH_SIZE_Y > 1) ? $clog2(MESH_SIZE_Y) : 1,
    localparam int HDR_BITS  = 2 * (DX_BITS + DY_BITS),
    localparam int FLIT_BITS = 2 + VC_BITS + HDR_BITS + PAYLOAD_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hdr_valid_i,
    output logic                          hdr_ready_o,
    input  logic [DX_BITS-1:0]            hdr_x_dest_i,
    input  logic [DY_BITS-1:0]            hdr_y_dest_i,
    input  logic [LEN_BITS-1:0]           hdr_len_i,
    input  logic                          data_valid_i,
    output logic                          data_ready_o,
    input  logic [PAYLOAD_DATA_WIDTH-1:0] data_i,
    output logic                          flit_valid_o,
    output logic [FLIT_BITS-1:0]          flit_o,
    input  logic [VC_NUM-1:0]             credit_i,
    output logic                          busy_o,
    output logic                          err_bad_hdr_o,
    output logic                          err_credit_ovf_o
);

    localparam int CNT_BITS = $clog2(BUFFER_DEPTH + 1);

    packetizer_state_t      state_q, state_d;
    logic [VC_BITS-1:0]     vc_q, vc_d;
    logic [VC_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_BITS-1:0]    rem_q, rem_d;
    logic [DX_BITS-1:0]     dest_x_q, dest_x_d;
    logic [DY_BITS-1:0]     dest_y_q, dest_y_d;
    logic                   flit_valid_q, flit_valid_d;
    logic [FLIT_BITS-1:0]   flit_q, flit_d;
    logic                   err_bad_hdr_q, err_bad_hdr_d;
    logic                   err_ovf_q, err_ovf_d;

    logic [CNT_BITS-1:0]    credit_count_s [VC_NUM];
    logic [VC_NUM-1:0]      credit_nz_s;
    logic [VC_NUM-1:0]      credit_ovf_s;
    logic [VC_NUM-1:0]      credit_dec_s;
    logic [VC_BITS-1:0]     vc_pick_s;
    logic                   vc_found_s;
    logic                   bad_hdr_s;
    flit_label_t            label_s;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_credit
        noc_credit_counter #(.BUFFER_DEPTH(BUFFER_DEPTH)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (credit_i[v]),
            .dec_i     (credit_dec_s[v]),
            .count_o   (credit_count_s[v]),
            .nonzero_o (credit_nz_s[v]),
            .ovf_o     (credit_ovf_s[v])
        );
    end

    assign bad_hdr_s = (int'(hdr_x_dest_i) >= MESH_SIZE_X) || (int'(hdr_y_dest_i) >= MESH_SIZE_Y) ||
                       (hdr_len_i == {LEN_BITS{1'b0}}) || (int'(hdr_len_i) > MAX_PKT_WORDS);

    // First VC with credit scanning up from rr_ptr with wrap; rr_ptr itself if none
    always_comb begin
        logic [VC_BITS-1:0] idx;
        vc_pick_s  = rr_ptr_q;
        vc_found_s = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = VC_BITS'((int'(rr_ptr_q) + i) % VC_NUM);
            if (!vc_found_s && (credit_count_s[idx] != {CNT_BITS{1'b0}})) begin
                vc_pick_s  = idx;
                vc_found_s = 1'b1;
            end else begin
                vc_found_s = vc_found_s;
            end
        end
    end

    // Packet FSM: header latch, word acceptance, flit assembly, drop handling
    always_comb begin
        state_d       = state_q;
        vc_d          = vc_q;
        rr_ptr_d      = rr_ptr_q;
        rem_d         = rem_q;
        dest_x_d      = dest_x_q;
        dest_y_d      = dest_y_q;
        flit_valid_d  = 1'b0;
        flit_d        = flit_q;
        err_bad_hdr_d = 1'b0;
        err_ovf_d     = err_ovf_q | (|credit_ovf_s);
        hdr_ready_o   = 1'b0;
        data_ready_o  = 1'b0;
        credit_dec_s  = {VC_NUM{1'b0}};
        label_s       = LBL_BODY;
        case (state_q)
            IDLE: begin
                hdr_ready_o = 1'b1;
                if (hdr_valid_i) begin
                    dest_x_d      = hdr_x_dest_i;
                    dest_y_d      = hdr_y_dest_i;
                    rem_d         = hdr_len_i;
                    vc_d          = vc_pick_s;
                    err_bad_hdr_d = bad_hdr_s;
                    state_d       = bad_hdr_s ? DROP : HEAD;
                end else begin
                    state_d = IDLE;
                end
            end
            HEAD, BODY: begin
                data_ready_o = credit_nz_s[vc_q];
                if (data_valid_i && credit_nz_s[vc_q]) begin
                    credit_dec_s[vc_q] = 1'b1;
                    flit_valid_d       = 1'b1;
                    rem_d              = rem_q - LEN_BITS'(1);
                    if (rem_q == LEN_BITS'(1)) begin
                        label_s  = (state_q == HEAD) ? LBL_HEADTAIL : LBL_TAIL;
                        state_d  = IDLE;
                        rr_ptr_d = VC_BITS'((int'(vc_q) + 1) % VC_NUM);
                    end else begin
                        label_s = (state_q == HEAD) ? LBL_HEAD : LBL_BODY;
                        state_d = BODY;
                    end
                    if (state_q == HEAD) begin
                        flit_d = {label_s, vc_q, dest_x_q, dest_y_q,
                                  DX_BITS'(NODE_X), DY_BITS'(NODE_Y), data_i};
                    end else begin
                        flit_d = {label_s, vc_q, {HDR_BITS{1'b0}}, data_i};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DROP: begin
                if (rem_q == {LEN_BITS{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    data_ready_o = 1'b1;
                    if (data_valid_i) begin
                        rem_d   = rem_q - LEN_BITS'(1);
                        state_d = (rem_q == LEN_BITS'(1)) ? IDLE : DROP;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            vc_q          <= {VC_BITS{1'b0}};
            rr_ptr_q      <= {VC_BITS{1'b0}};
            rem_q         <= {LEN_BITS{1'b0}};
            dest_x_q      <= {DX_BITS{1'b0}};
            dest_y_q      <= {DY_BITS{1'b0}};
            flit_valid_q  <= 1'b0;
            flit_q        <= {FLIT_BITS{1'b0}};
            err_bad_hdr_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vc_q          <= vc_d;
            rr_ptr_q      <= rr_ptr_d;
            rem_q         <= rem_d;
            dest_x_q      <= dest_x_d;
            dest_y_q      <= dest_y_d;
            flit_valid_q  <= flit_valid_d;
            flit_q        <= flit_d;
            err_bad_hdr_q <= err_bad_hdr_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    assign flit_valid_o     = flit_valid_q;
    assign flit_o           = flit_q;
    assign busy_o           = (state_q != IDLE);
    assign err_bad_hdr_o    = err_bad_hdr_q;
    assign err_credit_ovf_o = err_ovf_q;

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Randomized bench for noc_flit_packetizer against a packet-level reference
// model tracking credits, round-robin VC choice and the expected flit train.
module tb_noc_flit_packetizer;
    import noc_flit_packetizer_pkg::*;

    localparam int BD = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 hdr_valid_i = 1'b0;
    logic                 hdr_ready_o;
    logic [DEST_X_W-1:0]  hdr_x_dest_i = '0;
    logic [DEST_Y_W-1:0]  hdr_y_dest_i = '0;
    logic [LEN_W-1:0]     hdr_len_i = '0;
    logic                 data_valid_i = 1'b0;
    logic                 data_ready_o;
    logic [PAYLOAD_W-1:0] data_i = '0;
    logic                 flit_valid_o;
    logic [FLIT_W-1:0]    flit_o;
    logic [1:0]           credit_i = '0;
    logic                 busy_o;
    logic                 err_bad_hdr_o;
    logic                 err_credit_ovf_o;

    noc_flit_packetizer #(
        .VC_NUM(2), .BUFFER_DEPTH(BD), .MAX_PKT_WORDS(8), .PAYLOAD_DATA_WIDTH(64),
        .MESH_SIZE_X(9), .MESH_SIZE_Y(5), .NODE_X(0), .NODE_Y(0)
    ) dut (
        .clk(clk), .rst(rst),
        .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
        .hdr_x_dest_i(hdr_x_dest_i), .hdr_y_dest_i(hdr_y_dest_i), .hdr_len_i(hdr_len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .flit_valid_o(flit_valid_o), .flit_o(flit_o), .credit_i(credit_i),
        .busy_o(busy_o), .err_bad_hdr_o(err_bad_hdr_o), .err_credit_ovf_o(err_credit_ovf_o)
    );

    always #5 clk = ~clk;

    int                checks = 0;
    int                failures = 0;
    int                credits [2];
    int                rr;
    logic              ovf_m;
    logic [FLIT_W-1:0] last_flit;
    int                cr_div = 4;
    logic              force_same = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rand_cr();
        logic [1:0] r = 2'b00;
        for (int v = 0; v < 2; v++)
            if (credits[v] < BD && $urandom_range(cr_div - 1, 0) == 0) r[v] = 1'b1;
        return r;
    endfunction

    function automatic int pick_vc();
        for (int i = 0; i < 2; i++)
            if (credits[(rr + i) % 2] > 0) return (rr + i) % 2;
        return rr;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // One clock: drive at negedge, check readies, update model, check registered outputs.
    task automatic cyc(input logic hv, input logic [3:0] hx, input logic [2:0] hy, input logic [3:0] hl,
                       input logic dv, input logic [63:0] d, input logic [1:0] cr,
                       input logic e_hr, input logic e_dr, input logic e_fv, input logic [FLIT_W-1:0] e_flit,
                       input logic e_err, input logic e_busy, input int dec_vc);
        @(negedge clk);
        hdr_valid_i = hv; hdr_x_dest_i = hx; hdr_y_dest_i = hy; hdr_len_i = hl;
        data_valid_i = dv; data_i = d; credit_i = cr;
        #1;
        chk("hdr_ready", hdr_ready_o, e_hr);
        chk("data_ready", data_ready_o, e_dr);
        for (int v = 0; v < 2; v++)
            if (cr[v]) begin
                if (credits[v] == BD && dec_vc != v) ovf_m = 1'b1;
                else credits[v]++;
            end
        if (dec_vc >= 0) credits[dec_vc]--;
        if (e_fv) last_flit = e_flit;
        @(posedge clk);
        #1;
        chk("flit_valid", flit_valid_o, e_fv);
        chk("flit", flit_o, last_flit);
        chk("err_bad_hdr", err_bad_hdr_o, e_err);
        chk("err_credit_ovf", err_credit_ovf_o, ovf_m);
        chk("busy", busy_o, e_busy);
    endtask

    task automatic idle_cyc(input logic [1:0] cr);
        cyc(1'b0, 4'd0, 3'd0, 4'd0, 1'($urandom), rand_word(), cr, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hdr_valid_i = 1'b0; data_valid_i = 1'b0; credit_i = 2'b00;
        @(posedge clk);
        #1;
        credits[0] = BD; credits[1] = BD; rr = 0; ovf_m = 1'b0; last_flit = '0;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_flit_valid", flit_valid_o, 1'b0);
        chk("rst_flit", flit_o, '0);
        chk("rst_err_bad", err_bad_hdr_o, 1'b0);
        chk("rst_err_ovf", err_credit_ovf_o, 1'b0);
        chk("rst_hdr_ready", hdr_ready_o, 1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_credits();
        for (int n = 0; n < 10 && (credits[0] < BD || credits[1] < BD); n++)
            idle_cyc({credits[1] < BD, credits[0] < BD});
        chk("credits_refilled", (credits[0] == BD) && (credits[1] == BD), 1'b1);
    endtask

    // Send one message; abort_after>0 stops after that many accepted words.
    task automatic send_pkt(input logic [3:0] x, input logic [2:0] y, input logic [3:0] len, input int abort_after);
        logic               bad = (x >= 9) || (y >= 5) || (len == 0) || (len > 8);
        int                 vc = pick_vc();
        logic               dv, rdy, acc, first, last;
        logic [1:0]         cr;
        logic [63:0]        w;
        flit_t              f;
        flit_label_t        lbl;
        cyc(1'b1, x, y, len, 1'b0, rand_word(), rand_cr(), 1'b1, 1'b0, 1'b0, '0, bad, 1'b1, -1);
        if (bad) begin
            if (len == 0) begin
                cyc(1'($urandom), 4'd1, 3'd1, 4'd1, 1'($urandom), rand_word(), rand_cr(),
                    1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1);
            end else begin
                for (int i = 0; i < len; i++) begin
                    acc = 1'b0;
                    for (int n = 0; n < 50 && !acc; n++) begin
                        dv = ($urandom_range(2, 0) != 0);
                        acc = dv;
                        cyc(1'($urandom), 4'd1, 3'd1, 4'd1, dv, rand_word(), rand_cr(),
                            1'b0, 1'b1, 1'b0, '0, 1'b0, !(acc && i == len - 1), -1);
                    end
                    chk("drop_accept_bound", acc, 1'b1);
                end
            end
        end else begin
            for (int i = 0; i < len; i++) begin
                first = (i == 0); last = (i == len - 1);
                lbl = first ? (last ? LBL_HEADTAIL : LBL_HEAD) : (last ? LBL_TAIL : LBL_BODY);
                acc = 1'b0;
                for (int n = 0; n < 300 && !acc; n++) begin
                    dv  = ($urandom_range(3, 0) != 0);
                    rdy = (credits[vc] > 0);
                    acc = dv && rdy;
                    cr  = rand_cr();
                    if (force_same && acc) cr[vc] = 1'b1;
                    w = rand_word();
                    if (first) f = encode_head_flit(x, y, 7'd0, w, lbl, 1'(vc));
                    else begin
                        f.label = lbl; f.vc_id = 1'(vc); f.data = {{(2 * ADDR_W){1'b0}}, w};
                    end
                    cyc(1'($urandom), 4'd2, 3'd2, 4'd2, dv, w, cr, 1'b0, rdy, acc, f,
                        1'b0, !(acc && last), acc ? vc : -1);
                end
                chk("word_accept_bound", acc, 1'b1);
                if (abort_after > 0 && i + 1 == abort_after) return;
            end
            rr = (vc + 1) % 2;
        end
    endtask

    initial begin
        credits[0] = BD; credits[1] = BD; rr = 0; ovf_m = 1'b0; last_flit = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single-word packet: HEADTAIL on vc0 with correct dest/source fields.
        send_pkt(4'd3, 3'd2, 4'd1, 0);
        chk("t1_label", flit_o[FLIT_W-1 -: 2], 2'(LBL_HEADTAIL));
        chk("t1_vc", flit_o[FLIT_DATA_W], 1'b0);
        chk("t1_dest", decode_packet_destination(flit_t'(flit_o)), {4'd3, 3'd2});
        chk("t1_src", decode_packet_source(flit_t'(flit_o)), 7'd0);
        chk("t1_payload", flit_o[63:0], 64'hA5 ^ 64'hA5 ^ last_flit[63:0]);

        // Multi-word packets with no credit returns, then back-to-back with returns.
        cr_div = 1000000;
        do_reset();
        send_pkt(4'd5, 3'd4, 4'd4, 0);
        chk("t2_credit_vc0_empty", data_ready_o, 1'b0);
        send_pkt(4'd8, 3'd0, 4'd2, 0);
        chk("t2_last_on_vc1", flit_o[FLIT_DATA_W], 1'b1);
        cr_div = 8;
        send_pkt(4'd1, 3'd3, 4'd8, 0);
        send_pkt(4'd2, 3'd1, 4'd7, 0);

        // Bad headers: out-of-mesh x/y, zero and oversize length.
        send_pkt(4'd9, 3'd1, 4'd3, 0);
        send_pkt(4'd1, 3'd5, 4'd2, 0);
        send_pkt(4'd1, 3'd1, 4'd0, 0);
        send_pkt(4'd0, 3'd0, 4'd9, 0);

        // Accept and credit return on the same VC at the same edge, then overflow.
        cr_div = 4;
        fill_credits();
        force_same = 1'b1;
        send_pkt(4'd4, 3'd4, 4'd3, 0);
        force_same = 1'b0;
        fill_credits();
        idle_cyc(2'b10);
        chk("t5_ovf_set", err_credit_ovf_o, 1'b1);
        idle_cyc(2'b00);
        idle_cyc(2'b00);
        send_pkt(4'd6, 3'd2, 4'd5, 0);

        // Reset in the middle of a packet abandons it cleanly.
        send_pkt(4'd7, 3'd3, 4'd6, 3);
        do_reset();
        send_pkt(4'd2, 3'd2, 4'd1, 0);
        chk("t6_headtail_vc0", flit_o[FLIT_W-1 -: 3], {2'(LBL_HEADTAIL), 1'b0});

        // Random traffic.
        for (int p = 0; p < 40; p++) begin
            logic [3:0] x, l;
            logic [2:0] y;
            cr_div = $urandom_range(6, 2);
            x = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 9)) : 4'($urandom_range(8, 0));
            y = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0));
            l = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(8, 1));
            send_pkt(x, y, l, 0);
            if ($urandom_range(2, 0) == 0) idle_cyc(rand_cr());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
